gpio_serial_config_loader: RTL and testbench
============================================

Name: gpio_serial_config_loader

Overview:
Sequencer that loads per-pad configuration words into the daisy-chained user GPIO control-block shift chain feeding the digital mprj pads (mode, dm[2:0], slow/vtrip/ib_mode, analog enables, input disable, etc.). On a start request it fetches one word per pad from a config register file and shifts it out serially, farthest pad first, MSB first. It then issues a load strobe so all pads update their configuration simultaneously. Sits in the management/housekeeping domain between the GPIO config registers and the padframe control chain.

Parameters:
NUM_PADS, 27, digital pads in the chain (total mprj pads minus analog pads); >=1
CFG_BITS, 13, configuration bits per pad; >=2
CLK_DIV, 1, core cycles per serial_clock phase (low and high each last CLK_DIV cycles); >=1
AW, $clog2(NUM_PADS) (min 1), width of cfg_addr

Ports:
clock  input  1  core clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
xfer_start  input  1  request full-chain load; sampled only in IDLE
xfer_abort  input  1  synchronous abort; sampled in FETCH/SHIFT
cfg_addr  output  AW  pad index of the word being fetched (registered)
cfg_data  input  CFG_BITS  config word for cfg_addr; must be valid by the edge ending FETCH
serial_clock  output  1  chain shift clock; receivers sample on rising edge
serial_data_out  output  1  chain serial data
serial_load  output  1  chain parallel-load strobe
busy  output  1  transfer in progress
done  output  1  one-cycle pulse on successful completion
aborted  output  1  one-cycle pulse when an abort is taken

Behaviour:
- Reset (async, any state): state=IDLE; cfg_addr=0, serial_clock=0, serial_data_out=0, serial_load=0, busy=0, done=0, aborted=0; bit/divider/pad counters cleared. Reset mid-transfer issues no serial_load, so pads keep their prior config.
- All outputs registered. States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE: serial outputs 0, busy=0. xfer_start=1 -> FETCH, pad_idx=NUM_PADS-1, cfg_addr=NUM_PADS-1, busy=1.
- FETCH (1 cycle): at its ending edge capture cfg_data into shift reg, bit_cnt=CFG_BITS-1 -> SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles): serial_clock=0, serial_data_out=shreg[MSB] (changes only on entry to SHIFT_LO) -> SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles): serial_clock=1, data held stable. On exit: bit_cnt>0 -> shift shreg left, bit_cnt-- -> SHIFT_LO. bit_cnt==0 and pad_idx>0 -> pad_idx--, cfg_addr-- -> FETCH. bit_cnt==0 and pad_idx==0 -> LOAD.
- FETCH holds serial_clock=0 (stretched low phase); no glitch between pads.
- LOAD (CLK_DIV cycles): serial_clock=0, serial_data_out=0, serial_load=1 -> DONE.
- DONE (1 cycle): serial_load=0, done=1, busy=1 -> IDLE (busy=0 next cycle).
- Latency from start-sampling edge to done-high cycle: NUM_PADS*(1+2*CLK_DIV*CFG_BITS)+CLK_DIV+1 cycles. Exactly CFG_BITS*NUM_PADS rising serial_clock edges per transfer.
- xfer_start while busy: ignored, not queued. Held high through DONE: new transfer starts the cycle after return to IDLE.
- xfer_abort=1 in FETCH/SHIFT_LO/SHIFT_HI: next state IDLE; serial_clock=0, serial_data_out=0, no serial_load, aborted=1 for one cycle, busy=0. Ignored in IDLE/LOAD/DONE (LOAD is committed).
- Abort and start both high in IDLE: start wins.
- Counters sized to exact ranges; cfg_addr never exceeds NUM_PADS-1 and never wraps below 0.

Test Plan:
- Reset: assert reset mid-SHIFT_HI asynchronously -> all outputs 0 same cycle, no serial_load ever, IDLE after release.
- Basic, NUM_PADS=2, CFG_BITS=4, CLK_DIV=1, word[1]=4'hA, word[0]=4'h3: start at edge 0 -> cfg_addr 1 then 0; serial stream on rising serial_clock = 1,0,1,0,0,0,1,1; serial_load high cycle 19 only; done cycle 20; busy high cycles 1-20.
- CLK_DIV=3, defaults otherwise: each serial_clock phase exactly 3 cycles; 351 rising edges; done exactly 27*(1+78)+4 = 2137 cycles after start.
- Abort during pad 0 SHIFT_LO: aborted pulse next cycle, busy=0, serial_load never asserted; following start performs a full correct transfer.
- start pulsed while busy and held high through DONE: first transfer unaffected; second begins one cycle after IDLE re-entry.
- Scoreboard model of chain (NUM_PADS shift regs clocked on serial_clock, captured on serial_load) with random words -> captured config equals cfg words for every pad.

Source files
------------

// File: rtl/gpio_serial_config_loader.sv
// -----------------------------------------------------------------------------
// gpio_serial_config_loader
//
// Loads one configuration word per digital user pad into the daisy-chained GPIO
// control-block shift chain, then strobes a parallel load. All pads therefore
// switch to their new configuration at the same time.
//
// Words are fetched from an external config register file, farthest pad first,
// and each word is shifted out MSB first. The chain receivers sample
// serial_data_out on the rising edge of serial_clock. serial_data_out only
// changes when a low phase begins, so it is stable across every rising edge.
//
// Ports:
//   clock            core clock; all logic on the rising edge
//   reset            asynchronous, active-high reset
//   xfer_start       request a full-chain load; sampled only when idle
//   xfer_abort       synchronous abort; honoured during fetch and shift only
//   cfg_addr         pad index of the word being fetched (registered)
//   cfg_data         config word for cfg_addr; captured at the end of a fetch
//   serial_clock     chain shift clock
//   serial_data_out  chain serial data
//   serial_load      chain parallel-load strobe
//   busy             transfer in progress
//   done             one-cycle pulse on successful completion
//   aborted          one-cycle pulse when an abort is taken
// -----------------------------------------------------------------------------
module gpio_serial_config_loader #(
   parameter int unsigned NUM_PADS = 27,
   parameter int unsigned CFG_BITS = 13,
   parameter int unsigned CLK_DIV  = 1,
   parameter int unsigned AW       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                xfer_start,
   input  logic                xfer_abort,
   output logic [AW-1:0]       cfg_addr,
   input  logic [CFG_BITS-1:0] cfg_data,
   output logic                serial_clock,
   output logic                serial_data_out,
   output logic                serial_load,
   output logic                busy,
   output logic                done,
   output logic                aborted
);

   localparam int unsigned BW = $clog2(CFG_BITS);
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [AW-1:0] LastPad = AW'(NUM_PADS - 1);
   localparam logic [BW-1:0] LastBit = BW'(CFG_BITS - 1);
   localparam logic [DW-1:0] LastDiv = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StShiftLo,
      StShiftHi,
      StLoad,
      StDone
   } state_e;

   state_e state_q, state_d;

   // Datapath registers
   logic [AW-1:0]       addr_q,  addr_d;   // pad index, doubles as cfg_addr
   logic [BW-1:0]       bit_q,   bit_d;    // bits left in current word after this one
   logic [DW-1:0]       div_q,   div_d;    // cycles spent in current timed phase
   logic [CFG_BITS-1:0] shreg_q, shreg_d;

   // Output registers
   logic sclk_q,    sclk_d;
   logic sdo_q,     sdo_d;
   logic load_q,    load_d;
   logic busy_q,    busy_d;
   logic done_q,    done_d;
   logic aborted_q, aborted_d;

   logic div_last;
   logic abort_take;
   logic timed_phase;

   assign div_last    = (div_q == LastDiv);
   assign timed_phase = state_q inside {StShiftLo, StShiftHi, StLoad};

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      abort_take = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (xfer_start) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (xfer_abort) begin
               state_d    = StIdle;
               abort_take = 1'b1;
            end else begin
               state_d = StShiftLo;
            end
         end
         StShiftLo: begin
            if (xfer_abort) begin
               state_d    = StIdle;
               abort_take = 1'b1;
            end else if (div_last) begin
               state_d = StShiftHi;
            end
         end
         StShiftHi: begin
            if (xfer_abort) begin
               state_d    = StIdle;
               abort_take = 1'b1;
            end else if (div_last) begin
               if (bit_q != '0) begin
                  state_d = StShiftLo;
               end else if (addr_q != '0) begin
                  state_d = StFetch;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         // Once the load strobe starts the transfer is committed.
         StLoad: begin
            if (div_last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath next-state
   // --------------------------------------------------------------------------
   always_comb begin
      addr_d  = addr_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;

      // Divider restarts on every phase change and idles at zero elsewhere.
      if (timed_phase && (state_d == state_q)) begin
         div_d = div_q + DW'(1);
      end else begin
         div_d = '0;
      end

      if (state_q == StIdle && state_d == StFetch) begin
         addr_d = LastPad;
      end

      if (state_q == StFetch && state_d == StShiftLo) begin
         shreg_d = cfg_data;
         bit_d   = LastBit;
      end

      if (state_q == StShiftHi && state_d == StShiftLo) begin
         // Rotate rather than shift; only the top bit is ever driven out,
         // and the word is reloaded before the rotated bits could reappear.
         shreg_d = {shreg_q[CFG_BITS-2:0], shreg_q[CFG_BITS-1]};
         bit_d   = bit_q - BW'(1);
      end

      if (state_q == StShiftHi && state_d == StFetch) begin
         addr_d = addr_q - AW'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Output next-state: every output is registered from the next state, so
   // outputs line up with the state they describe.
   // --------------------------------------------------------------------------
   always_comb begin
      sclk_d    = (state_d == StShiftHi);
      load_d    = (state_d == StLoad);
      done_d    = (state_d == StDone);
      busy_d    = (state_d != StIdle);
      aborted_d = abort_take;

      // Data only moves when a low phase begins; fetch keeps the previous bit
      // so the stretched low phase between pads is glitch free.
      sdo_d = sdo_q;
      if (state_q == StFetch && state_d == StShiftLo) begin
         sdo_d = cfg_data[CFG_BITS-1];
      end else if (state_q == StShiftHi && state_d == StShiftLo) begin
         sdo_d = shreg_q[CFG_BITS-2];
      end else if (state_d inside {StIdle, StLoad, StDone}) begin
         sdo_d = 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Datapath and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         bit_q     <= '0;
         div_q     <= '0;
         shreg_q   <= '0;
         sclk_q    <= 1'b0;
         sdo_q     <= 1'b0;
         load_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         shreg_q   <= shreg_d;
         sclk_q    <= sclk_d;
         sdo_q     <= sdo_d;
         load_q    <= load_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign cfg_addr        = addr_q;
   assign serial_clock    = sclk_q;
   assign serial_data_out = sdo_q;
   assign serial_load     = load_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign aborted         = aborted_q;

endmodule

// File: tb/tb_gpio_serial_config_loader.sv
// -----------------------------------------------------------------------------
// Bench for gpio_serial_config_loader.
// A driver issues transfers with random config words and pushes the expected
// outcome (done or abort, the cycle it must appear, the words every pad must
// hold) into a queue. A monitor models the pad chain as one long shift
// register clocked by serial_clock and captured on serial_load, and pops and
// compares whenever the DUT reports done or aborted.
// -----------------------------------------------------------------------------
module tb_gpio_serial_config_loader;

   localparam int unsigned NUM_PADS  = 3;
   localparam int unsigned CFG_BITS  = 5;
   localparam int unsigned CLK_DIV   = 2;
   localparam int unsigned AW        = 2;
   localparam int unsigned PAD_CYC   = 1 + 2 * CLK_DIV * CFG_BITS;
   localparam int unsigned SHIFT_CYC = NUM_PADS * PAD_CYC;
   localparam int unsigned LATENCY   = SHIFT_CYC + CLK_DIV + 1;
   localparam int unsigned CHAIN     = NUM_PADS * CFG_BITS;

   typedef struct packed {
      logic             is_abort;
      logic [31:0]      cyc;
      logic [CHAIN-1:0] words;
   } exp_t;

   logic                clock      = 1'b0;
   logic                reset      = 1'b0;
   logic                xfer_start = 1'b0;
   logic                xfer_abort = 1'b0;
   logic [AW-1:0]       cfg_addr;
   logic [CFG_BITS-1:0] cfg_data;
   logic                serial_clock;
   logic                serial_data_out;
   logic                serial_load;
   logic                busy;
   logic                done;
   logic                aborted;

   logic [CFG_BITS-1:0] cfg_mem [NUM_PADS];
   logic [AW+5:0]       outs;

   exp_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;

   gpio_serial_config_loader #(
      .NUM_PADS(NUM_PADS),
      .CFG_BITS(CFG_BITS),
      .CLK_DIV (CLK_DIV),
      .AW      (AW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .xfer_start     (xfer_start),
      .xfer_abort     (xfer_abort),
      .cfg_addr       (cfg_addr),
      .cfg_data       (cfg_data),
      .serial_clock   (serial_clock),
      .serial_data_out(serial_data_out),
      .serial_load    (serial_load),
      .busy           (busy),
      .done           (done),
      .aborted        (aborted)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Config register file: combinational read of the addressed word.
   assign cfg_data = (32'(cfg_addr) < NUM_PADS) ? cfg_mem[cfg_addr] : '0;
   assign outs     = {cfg_addr, serial_clock, serial_data_out, serial_load, busy, done, aborted};

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Pad p ends up holding the slice [p*CFG_BITS +: CFG_BITS] of the chain.
   function automatic logic [CHAIN-1:0] pack_words();
      logic [CHAIN-1:0] w;
      w = '0;
      for (int p = 0; p < NUM_PADS; p++) w[p*CFG_BITS +: CFG_BITS] = cfg_mem[p];
      return w;
   endfunction

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   logic [CHAIN-1:0] chain       = '0;
   logic [CHAIN-1:0] captured    = '0;
   int unsigned      edges       = 0;
   int unsigned      loads       = 0;
   int unsigned      hi_len      = 0;
   logic             prev_sclk   = 1'b0;
   logic             sdo_at_rise = 1'b0;
   exp_t             cur;

   always @(negedge clock) begin
      if (reset) begin
         chain     = '0;
         edges     = 0;
         loads     = 0;
         hi_len    = 0;
         prev_sclk = 1'b0;
      end else begin
         if (busy) check("addr_range", 64'(32'(cfg_addr) < NUM_PADS), 64'd1);
         if (serial_clock && !prev_sclk) begin
            chain       = {chain[CHAIN-2:0], serial_data_out};
            edges       = edges + 1;
            hi_len      = 0;
            sdo_at_rise = serial_data_out;
         end
         if (serial_clock) begin
            hi_len = hi_len + 1;
            check("sdo_stable_high", 64'(serial_data_out), 64'(sdo_at_rise));
         end
         if (!serial_clock && prev_sclk && !aborted)
            check("sclk_high_len", 64'(hi_len), 64'(CLK_DIV));
         if (serial_load) begin
            captured = chain;
            loads    = loads + 1;
            check("load_lines", 64'({serial_clock, serial_data_out}), 64'd0);
         end
         if (done || aborted) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", 64'd0, 64'd1);
            end else begin
               cur = exp_q.pop_front();
               check("event_kind", 64'(aborted), 64'(cur.is_abort));
               check("event_cycle", 64'(cyc), 64'(cur.cyc));
               if (cur.is_abort) begin
                  check("abort_outputs",
                        64'({busy, serial_clock, serial_data_out, serial_load}), 64'd0);
                  check("abort_no_load", 64'(loads), 64'd0);
               end else begin
                  check("done_busy", 64'(busy), 64'd1);
                  check("sclk_rises", 64'(edges), 64'(CHAIN));
                  check("load_cycles", 64'(loads), 64'(CLK_DIV));
                  check("captured_config", 64'(captured), 64'(cur.words));
               end
            end
            edges = 0;
            loads = 0;
         end
         prev_sclk = serial_clock;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic randomize_words();
      for (int p = 0; p < NUM_PADS; p++) cfg_mem[p] = CFG_BITS'($urandom);
   endtask

   task automatic push_exp(input logic is_abort, input int unsigned at);
      exp_t e;
      e.is_abort = is_abort;
      e.cyc      = at;
      e.words    = pack_words();
      exp_q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 3 * LATENCY && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   // Full transfer; with_abort raises abort together with start in idle.
   task automatic run_full(input logic with_abort);
      randomize_words();
      xfer_start = 1'b1;
      xfer_abort = with_abort;
      push_exp(1'b0, cyc + LATENCY);
      tick();
      xfer_start = 1'b0;
      xfer_abort = 1'b0;
      check("fetch_first_addr", 64'(cfg_addr), 64'(NUM_PADS - 1));
      check("fetch_busy", 64'(busy), 64'd1);
      drain();
   endtask

   // Abort raised k cycles after the start cycle; ignored once loading.
   task automatic run_abort(input int unsigned k);
      int unsigned n;
      randomize_words();
      n          = cyc;
      xfer_start = 1'b1;
      if (k <= SHIFT_CYC) push_exp(1'b1, n + k + 1);
      else                push_exp(1'b0, n + LATENCY);
      tick();
      xfer_start = 1'b0;
      repeat (k - 1) tick();
      xfer_abort = 1'b1;
      tick();
      xfer_abort = 1'b0;
      drain();
   endtask

   initial begin
      int unsigned n;
      for (int p = 0; p < NUM_PADS; p++) cfg_mem[p] = '0;

      #1 reset = 1'b1;
      #1 check("reset_outputs", 64'(outs), 64'd0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      tick();
      check("idle_outputs", 64'(outs), 64'd0);

      // Start and abort together in idle: start wins.
      run_full(1'b1);

      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         run_full(1'b0);
      end

      // Abort in the first low phase of the last pad fetched.
      run_abort(SHIFT_CYC - PAD_CYC + 2);
      run_full(1'b0);

      for (int i = 0; i < 8; i++) begin
         run_abort($urandom_range(1, LATENCY));
         run_full(1'b0);
      end

      // Abort while idle is ignored.
      xfer_abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_abort_ignored", 64'({busy, aborted}), 64'd0);
      end
      xfer_abort = 1'b0;

      // Start pulsed while busy, then held high through done.
      randomize_words();
      n          = cyc;
      xfer_start = 1'b1;
      push_exp(1'b0, n + LATENCY);
      push_exp(1'b0, n + 2 * LATENCY + 1);
      tick();
      xfer_start = 1'b0;
      repeat (3) tick();
      xfer_start = 1'b1;
      tick();
      xfer_start = 1'b0;
      while (cyc < n + LATENCY - 3) tick();
      xfer_start = 1'b1;
      while (cyc < n + LATENCY + 2) tick();
      xfer_start = 1'b0;
      drain();

      // Asynchronous reset in the middle of a high phase.
      randomize_words();
      n          = cyc;
      xfer_start = 1'b1;
      push_exp(1'b0, n + LATENCY);
      tick();
      xfer_start = 1'b0;
      while (cyc < n + PAD_CYC + 2 + CLK_DIV) tick();
      check("pre_reset_sclk", 64'(serial_clock), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("reset_async_outputs", 64'(outs), 64'd0);
      check("reset_no_load", 64'(loads), 64'd0);
      exp_q.delete();
      @(posedge clock);
      @(posedge clock);
      #3 reset = 1'b0;
      tick();
      check("post_reset_idle", 64'(outs), 64'd0);
      run_full(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
